// File: rtl/afm_pkg.sv
// Shared constants and types for the AFM UART blocks.
// The default bit period is derived from the system clock and line rate so
// that every UART instance agrees on it unless a caller overrides it.
package afm_pkg;

  localparam int unsigned CLK_FREQ_HZ       = 12_000_000;
  localparam int unsigned UART_BAUD         = 115_200;
  // 12 MHz / 115200 baud = 104 clocks per serial bit (integer division).
  localparam int unsigned UART_CLKS_PER_BIT = CLK_FREQ_HZ / UART_BAUD;

  // Raw state encodings, kept as plain constants for older code that
  // compares against fixed bit patterns.
  localparam logic [2:0] UART_ST_IDLE  = 3'd0;
  localparam logic [2:0] UART_ST_START = 3'd1;
  localparam logic [2:0] UART_ST_DATA  = 3'd2;
  localparam logic [2:0] UART_ST_STOP  = 3'd3;
  localparam logic [2:0] UART_ST_BREAK = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = UART_ST_IDLE,
    S_START = UART_ST_START,
    S_DATA  = UART_ST_DATA,
    S_STOP  = UART_ST_STOP,
    S_BREAK = UART_ST_BREAK
  } uart_rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// RESET_VAL sets the value both flops take during reset, so an idle-high
// line never shows a false edge when reset is released.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; only q is safe to use in clk-domain logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-entry output holding register.
//
// Output handshake: data is valid while valid=1; a transfer happens on any
// clock edge where valid=1 and ready=1. While valid=1 and ready=0, data is
// held unchanged. A byte arriving while the holding register is full and not
// being drained in the same cycle is dropped and overrun pulses for one cycle.
// A bad stop bit pulses frame_err for one cycle and the byte is discarded.
//
// The FSM state is the internal signal "state" (type uart_rx_state_t) so
// checkers can bind to it directly.
module uart_rx
  import afm_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  // Half a bit period lands the first sample near the centre of the start bit.
  localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);

  logic           rxs;
  uart_rx_state_t state;
  logic [TW-1:0]  timer;
  logic [2:0]     bit_idx;
  logic [7:0]     shreg;
  logic           timer_done;
  logic           stop_sample;
  logic           deliver;
  logic           bad_stop;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rxs)
  );

  // Sample-point decode shared by the FSM and the output register.
  always_comb begin
    timer_done  = (timer == '0);
    stop_sample = (state == S_STOP) && timer_done;
    deliver     = stop_sample && rxs;
    bad_stop    = stop_sample && !rxs;
  end

  // Receive FSM: bit timer, bit index and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!rxs) begin
            state <= S_START;
            timer <= HALF_LOAD;
          end
        end
        S_START: begin
          if (timer_done) begin
            if (!rxs) begin
              state   <= S_DATA;
              timer   <= FULL_LOAD;
              bit_idx <= '0;
            end else begin
              // Line went back high before mid start bit: a glitch.
              state <= S_IDLE;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_DATA: begin
          if (timer_done) begin
            // LSB arrives first, so shift in from the MSB side.
            shreg   <= {rxs, shreg[7:1]};
            timer   <= FULL_LOAD;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_STOP: begin
          if (timer_done) begin
            state <= rxs ? S_IDLE : S_BREAK;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_BREAK: begin
          // Wait for the line to return high; a held-low line is not a start.
          if (rxs) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Output holding register with valid/ready handshake and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= bad_stop;
      overrun   <= 1'b0;
      if (deliver) begin
        if (!valid || ready) begin
          data  <= shreg;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx with a 16-clock bit period.
// A negedge monitor records handshakes and error pulses; the main sequence
// compares those records against hand-computed expectations.
module tb_uart_rx;
  import afm_pkg::*;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;

  int tests_run    = 0;
  int tests_failed = 0;

  // Monitor records
  int         got_cnt  = 0;
  int         fe_cnt   = 0;
  int         ov_cnt   = 0;
  int         vld_cyc  = 0;
  int         both_cnt = 0;
  int         long_cnt = 0;
  logic [7:0] got_mem [0:63];
  logic       prev_fe  = 1'b0;
  logic       prev_ov  = 1'b0;

  // Scoreboard
  logic [7:0] exp_q[$];
  int g0, f0, o0, v0;

  // Clock / reset block
  always #5 clk = ~clk;

  uart_rx #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  // Monitor, sampled on the falling edge away from the active edge.
  always @(negedge clk) begin
    if (valid && ready) begin
      got_mem[got_cnt] <= data;
      got_cnt          <= got_cnt + 1;
    end
    if (valid)                prev_fe <= prev_fe;
    if (valid)                vld_cyc <= vld_cyc + 1;
    if (frame_err)            fe_cnt  <= fe_cnt + 1;
    if (overrun)              ov_cnt  <= ov_cnt + 1;
    if (frame_err && overrun) both_cnt <= both_cnt + 1;
    if ((frame_err && prev_fe) || (overrun && prev_ov)) long_cnt <= long_cnt + 1;
    prev_fe <= frame_err;
    prev_ov <= overrun;
  end

  // Driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    step(CPB);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    g0 = got_cnt;
    f0 = fe_cnt;
    o0 = ov_cnt;
    v0 = vld_cyc;
  endtask

  // Compare every byte received since the last snap against exp_q.
  task automatic check_bytes(input string tag);
    check({tag, "_count"}, got_cnt - g0, exp_q.size());
    for (int i = 0; i < got_cnt - g0; i++) begin
      if (exp_q.size() > 0) check({tag, "_byte"}, got_mem[g0 + i], exp_q.pop_front());
    end
    exp_q.delete();
  endtask

  initial begin
    rst   = 1'b1;
    rx    = 1'b1;
    ready = 1'b1;
    step(3);

    // Reset state
    check("rst_state", dut.state, S_IDLE);
    check("rst_data", data, 8'h00);
    check("rst_valid", valid, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_ovr", overrun, 1'b0);
    rst = 1'b0;
    step(4);

    // Single byte, ready held high
    snap();
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    step(4);
    check_bytes("a5");
    check("a5_vld_cycles", vld_cyc - v0, 1);
    check("a5_ferr", fe_cnt - f0, 0);
    check("a5_ovr", ov_cnt - o0, 0);
    check("a5_valid_low", valid, 1'b0);

    // Short low glitch must not start a frame
    snap();
    rx = 1'b0;
    step(6);
    rx = 1'b1;
    step(24);
    check("glitch_state", dut.state, S_IDLE);
    check("glitch_bytes", got_cnt - g0, 0);
    check("glitch_valid", valid, 1'b0);
    check("glitch_ferr", fe_cnt - f0, 0);
    check("glitch_ovr", ov_cnt - o0, 0);

    // Bad stop bit, line held low, then a good byte
    snap();
    send_frame(8'h3C, 1'b0);
    step(40);
    check("brk_state", dut.state, S_BREAK);
    check("brk_ferr", fe_cnt - f0, 1);
    check("brk_bytes", got_cnt - g0, 0);
    rx = 1'b1;
    step(CPB);
    check("brk_exit", dut.state, S_IDLE);
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    step(4);
    check_bytes("after_brk");
    check("after_brk_ferr", fe_cnt - f0, 1);
    check("after_brk_ovr", ov_cnt - o0, 0);

    // Holding register full: second byte dropped with overrun
    snap();
    ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    step(4);
    check("ovr_valid", valid, 1'b1);
    check("ovr_data", data, 8'h11);
    check("ovr_pulses", ov_cnt - o0, 1);
    check("ovr_ferr", fe_cnt - f0, 0);
    check("ovr_no_hs", got_cnt - g0, 0);
    step(10);
    check("ovr_data_held", data, 8'h11);
    exp_q.push_back(8'h11);
    ready = 1'b1;
    step(1);
    check("ovr_valid_clr", valid, 1'b0);
    step(3);
    check_bytes("ovr_hs");

    // Back-to-back bytes, no idle gap
    snap();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    step(4);
    check_bytes("b2b");
    check("b2b_ferr", fe_cnt - f0, 0);
    check("b2b_ovr", ov_cnt - o0, 0);

    // Reset during data bit 4 of 0x81; the sender abandons the byte too
    snap();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(((8'h81 >> i) & 8'h01) != 8'h00);
    rx = 1'b0;
    step(CPB / 2);
    rst = 1'b1;
    step(1);
    check("mid_rst_state", dut.state, S_IDLE);
    check("mid_rst_valid", valid, 1'b0);
    rst = 1'b0;
    rx  = 1'b1;
    step(2 * CPB);
    check("mid_rst_bytes", got_cnt - g0, 0);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    step(4);
    check_bytes("post_rst");
    check("post_rst_ferr", fe_cnt - f0, 0);
    check("post_rst_ovr", ov_cnt - o0, 0);

    // Pulse-shape invariants over the whole run
    check("err_together", both_cnt, 0);
    check("err_multicycle", long_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104, meaning clock cycles per serial bit; legal range 8..65535.
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port rx  input  1  asynchronous serial line, 8N1, idle high, LSB first.
REQ-005 SHALL have port data  output  8  received byte, valid while valid=1.
REQ-006 SHALL have port valid  output  1  byte available in the output holding register.
REQ-007 SHALL have port ready  input  1  consumer accepts data on a cycle with valid=1 and ready=1.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-009 SHALL have port overrun  output  1  one-cycle pulse when a good byte is dropped because the holding register is full.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value rxs.
REQ-011 SHALL implement FSM states IDLE, START, DATA, STOP, BREAK with a bit-timer counter and a 3-bit bit index.
REQ-012 IDLE: on rxs=0, go to START and load the timer with CLKS_PER_BIT/2-1 (integer division).
REQ-013 START: at timer expiry, rxs=0 goes to DATA with the timer reloaded to CLKS_PER_BIT-1; rxs=1 is a glitch and returns to IDLE with no output.
REQ-014 DATA: at each expiry, shift rxs into the shift register MSB-side (LSB first on the line) and reload the timer; after the 8th sample, go to STOP.
REQ-015 STOP: at expiry with rxs=1, deliver the byte and go to IDLE; with rxs=0, pulse frame_err, discard the byte, and go to BREAK.
REQ-016 BREAK: remain until rxs=1, then go to IDLE; no start detection occurs in BREAK.
REQ-017 Delivery: if valid=0, or if valid=1 and ready=1 in the same cycle, load data and set valid on the next clock.
REQ-018 Delivery into a full register: if valid=1 and ready=0, pulse overrun, keep the old data unchanged, and drop the new byte.
REQ-019 valid SHALL clear on the clock after a handshake unless a new byte loads in that same cycle.
REQ-020 data SHALL be stable whenever valid=1 and ready=0.
REQ-021 Latency: valid rises 1 clock after the mid-stop-bit sample, about 9.5 bit times plus 3 clocks after the line falling edge.
REQ-022 The timer width SHALL be $clog2(CLKS_PER_BIT); the counter wraps only by reload, never by overflow.
REQ-023 frame_err and overrun SHALL never be asserted for more than one cycle per byte and SHALL never be asserted together.

Reset
REQ-024 On rst=1 at a clock edge: state=IDLE; timer=0; bit index=0; shift register=0; data=8'h00; valid=0; frame_err=0; overrun=0; synchronizer flops=1.
REQ-025 Reset mid-byte SHALL abandon the byte with no output pulse; the next falling edge after reset is treated as a new start bit.

Structure
REQ-026 The shared package afm_pkg SHALL hold the UART default CLKS_PER_BIT constant (clock frequency / baud) and the uart_rx_state_t enum.
REQ-027 The synchronizer SHALL be the sub-module sync_2ff (parameter RESET_VAL=1), reusable by other asynchronous inputs.
REQ-028 No other sub-modules; the target size is about 150-250 lines of RTL.

Verification
REQ-029 With CLKS_PER_BIT=16 and ready=1, send 0xA5 -> one valid cycle with data=0xA5; frame_err=0 and overrun=0.
REQ-030 Drive a 6-clock low glitch on rx (less than 8 clocks) -> state returns to IDLE; valid, frame_err and overrun stay 0.
REQ-031 Send 0x3C with stop bit forced 0, then hold rx low for 40 clocks, then send 0x55 -> one frame_err pulse, no valid for 0x3C, then 0x55 delivered.
REQ-032 Hold ready=0 and send 0x11 then 0x22 -> valid=1 with data=0x11 held, one overrun pulse; raising ready gives one handshake, then valid=0.
REQ-033 Hold ready=1 and send 0x00 and 0xFF back-to-back with no idle gap -> both delivered in order, no errors.
REQ-034 Assert rst for one cycle during data bit 4 of 0x81, then send 0x7E -> no output for 0x81; 0x7E is delivered correctly.
